stream_rx_capture: RTL and testbench

- Receiving end of the pulse-driven stream interface: data_in / sid_in / data_valid, one-cycle valid pulses, no backpressure.
- Captures every accepted beat, with its stream ID, into an internal first-word-fall-through FIFO.
- Re-presents the beats on a valid/ready master port for downstream checkers or scoreboards.
- Counts accepted and dropped beats and flags overflow, because the sender cannot be stalled.

---
 rtl/stream_rx_capture.sv | 60 ++++++
 tb/tb_stream_rx_capture.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/stream_rx_capture.sv
// stream_rx_capture: captures pulse-driven stream beats into a FWFT FIFO and re-presents them on a valid/ready port
module stream_rx_capture #(
  parameter int DATA_WIDTH = 512,
  parameter int SID_WIDTH  = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic [SID_WIDTH-1:0]     sid_in,
  input  logic                     data_valid,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic [SID_WIDTH-1:0]     m_sid,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  output logic [CNT_WIDTH-1:0]     drop_count,
  output logic [31:0]              rx_count,
  input  logic                     clr_stats
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int EW = SID_WIDTH + DATA_WIDTH;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop, full, accept, drop;
  assign m_valid = fill_level != '0;
  assign pop     = m_valid & m_ready;
  assign full    = fill_level == FW'(DEPTH);
  assign accept  = data_valid & (~full | pop);
  assign drop    = data_valid & ~accept;
  assign {m_sid, m_data} = m_valid ? mem[rd_ptr] : '0;
  // storage is written only; it is never cleared since fill_level gates visibility
  always_ff @(posedge clk)
    if (accept) mem[wr_ptr] <= {sid_in, data_in};
  // pointers and occupancy; a pop on a full FIFO frees the slot the same edge's push uses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(accept);
      rd_ptr     <= rd_ptr + AW'(pop);
      fill_level <= fill_level + FW'(accept) - FW'(pop);
    end
  // statistics; a clear still records a drop or accept on the same edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
      rx_count   <= '0;
    end else begin
      overflow   <= (overflow & ~clr_stats) | drop;
      drop_count <= clr_stats ? CNT_WIDTH'(drop) : drop_count + CNT_WIDTH'(drop && drop_count != '1);
      rx_count   <= (clr_stats ? 32'd0 : rx_count) + 32'(accept);
    end
endmodule

// File: tb/tb_stream_rx_capture.sv
// tb_stream_rx_capture: randomized and directed scoreboard bench for stream_rx_capture
module tb_stream_rx_capture;
  localparam int DW = 512;
  localparam int SW = 8;
  localparam int DEPTH = 16;
  localparam int CW = 16;
  localparam int EW = SW + DW;
  logic clk = 0;
  logic rst_n = 0;
  logic [DW-1:0] data_in = '0;
  logic [SW-1:0] sid_in = '0;
  logic data_valid = 0;
  logic [DW-1:0] m_data;
  logic [SW-1:0] m_sid;
  logic m_valid;
  logic m_ready = 0;
  logic [$clog2(DEPTH):0] fill_level;
  logic overflow;
  logic [CW-1:0] drop_count;
  logic [31:0] rx_count;
  logic clr_stats = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] mq[$];
  logic [EW-1:0] exp_q[$];
  int unsigned rx_m;
  longint drop_m;
  bit ovf_m;
  int max_fill;

  stream_rx_capture #(.DATA_WIDTH(DW), .SID_WIDTH(SW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .sid_in(sid_in), .data_valid(data_valid),
    .m_data(m_data), .m_sid(m_sid), .m_valid(m_valid), .m_ready(m_ready),
    .fill_level(fill_level), .overflow(overflow), .drop_count(drop_count),
    .rx_count(rx_count), .clr_stats(clr_stats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a plain queue of stored beats plus counters from the accept/drop rules
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      rx_m = 0;
      drop_m = 0;
      ovf_m = 0;
    end else begin
      automatic bit p = mq.size() > 0 && m_ready;
      automatic bit a = data_valid && (mq.size() < DEPTH || p);
      if (clr_stats) begin
        rx_m = 0;
        drop_m = 0;
        ovf_m = 0;
      end
      if (p) void'(mq.pop_front());
      if (a) begin
        mq.push_back({sid_in, data_in});
        exp_q.push_back({sid_in, data_in});
        rx_m++;
      end else if (data_valid) begin
        ovf_m = 1;
        if (drop_m < (64'd1 << CW) - 1) drop_m++;
      end
    end
  end

  // monitor: sampled mid-cycle, pops the scoreboard on every handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", EW'(m_valid), 0);
      chk("rst_fill", EW'(fill_level), 0);
      chk("rst_stats", EW'({overflow, drop_count, rx_count}), 0);
      chk("rst_data", {m_sid, m_data}, 0);
    end else begin
      if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
      chk("fill_level", EW'(fill_level), EW'(mq.size()));
      chk("m_valid", EW'(m_valid), EW'(mq.size() > 0));
      chk("overflow", EW'(overflow), EW'(ovf_m));
      chk("drop_count", EW'(drop_count), EW'(drop_m));
      chk("rx_count", EW'(rx_count), EW'(rx_m));
      if (mq.size() > 0) chk("head", {m_sid, m_data}, mq[0]);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
        else chk("sb_beat", {m_sid, m_data}, exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic v, input logic [SW-1:0] s, input logic [DW-1:0] d, input logic r, input logic c);
    data_valid = v;
    sid_in = s;
    data_in = d;
    m_ready = r;
    clr_stats = c;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    logic [DW-1:0] a5;
    a5 = {(DW / 8){8'hA5}};
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    step(1, 8'd3, a5, 0, 0);
    repeat (6) step(0, 0, 0, 0, 0);
    chk("single_sid", EW'(m_sid), 3);
    chk("single_data", EW'(m_data), EW'(a5));
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 17; i++) step(1, SW'(i), rnd_data(), 0, 0);
    step(0, 0, 0, 0, 0);
    chk("full_fill", EW'(fill_level), 16);
    chk("full_drop", EW'(drop_count), 1);
    chk("full_rx", EW'(rx_count), 17);
    step(1, 8'h40, rnd_data(), 1, 0);
    step(0, 0, 0, 0, 0);
    chk("push_pop_full_fill", EW'(fill_level), 16);
    chk("push_pop_full_drop", EW'(drop_count), 1);
    step(1, 8'h41, rnd_data(), 0, 1);
    step(0, 0, 0, 0, 0);
    chk("clr_drop_ovf", EW'({overflow, drop_count}), EW'({1'b1, 16'd1}));
    chk("clr_drop_fill", EW'(fill_level), 16);
    repeat (20) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    max_fill = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, SW'(i), rnd_data(), 1, 0);
      step(0, 0, 0, 1, 0);
    end
    chk("alt_max_fill", EW'(max_fill), 1);
    chk("alt_rx", EW'(rx_count), 40);
    chk("alt_ovf", EW'(overflow), 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, SW'($urandom), rnd_data(),
           i < 200 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0,
           $urandom_range(0, 24) == 0);
    repeat (20) step(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, SW'(i + 8'h80), rnd_data(), 0, 0);
    chk("pre_rst_fill", EW'(fill_level), 5);
    #3 rst_n = 0;
    #1;
    chk("async_valid", EW'(m_valid), 0);
    chk("async_fill", EW'(fill_level), 0);
    chk("async_stats", EW'({overflow, drop_count, rx_count}), 0);
    @(posedge clk);
    #1 rst_n = 1;
    step(1, 8'h77, a5, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("post_rst_fill", EW'(fill_level), 1);
    chk("post_rst_sid", EW'(m_sid), EW'(8'h77));
    repeat (3) step(0, 0, 0, 1, 0);
    chk("sb_drained", EW'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
